// File: rtl/prio_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : prio_pkg
//  Brief    : Shared constants for the sequential priority encoder:
//             width-mode codes, the mode-to-mask lookup and the FSM states.
//  Revision : 1.0  initial release
// ============================================================================
package prio_pkg;

    // Width-mode encodings carried on Z
    localparam logic [1:0] MODE_4    = 2'b00;
    localparam logic [1:0] MODE_8    = 2'b01;
    localparam logic [1:0] MODE_16   = 2'b10;
    localparam logic [1:0] MODE_RSVD = 2'b11;

    // FSM states
    typedef logic [0:0] state_t;
    localparam state_t IDLE  = 1'b0;
    localparam state_t DRAIN = 1'b1;

    // Lines that survive the selected width mode; the reserved mode keeps nothing
    function automatic logic [15:0] mask_of(input logic [1:0] z);
        logic [15:0] m;
        case (z)
            MODE_4:  m = 16'h000F;
            MODE_8:  m = 16'h00FF;
            MODE_16: m = 16'hFFFF;
            default: m = 16'h0000;
        endcase
        return m;
    endfunction

endpackage : prio_pkg
`default_nettype wire

// File: rtl/prio_find16.sv
`default_nettype none
// ============================================================================
//  Module   : prio_find16
//  Brief    : Combinational highest-set-bit finder over a 16-bit vector.
//             idx is 0 when the vector is empty; any flags a non-empty vector.
//  Revision : 1.0  initial release
// ============================================================================
module prio_find16 (
    input  logic [15:0] vec,
    output logic [3:0]  idx,
    output logic        any
);

    // Scan upward so the highest set bit is the last one written
    always_comb begin
        idx = 4'd0;
        for (int i = 0; i < 16; i++) begin
            if (vec[i]) begin
                idx = 4'(i);
            end
        end
    end

    assign any = |vec;

endmodule : prio_find16
`default_nettype wire

// File: rtl/priority_encoder_seq.sv
`default_nettype none
// ============================================================================
//  Module   : priority_encoder_seq
//  Brief    : Latches a width-masked request vector and drains it as binary
//             line codes, highest index first, one per valid/ready transfer.
//  Revision : 1.0  initial release
// ============================================================================
module priority_encoder_seq
    import prio_pkg::*;
#(
    parameter int LINES  = 16,
    parameter int CODE_W = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              E,
    input  logic [1:0]        Z,
    input  logic [LINES-1:0]  Y,
    input  logic              load,
    output logic              load_rdy,
    output logic [CODE_W-1:0] X,
    output logic              valid,
    input  logic              ready,
    output logic              none,
    output logic [4:0]        pending
);

    state_t           state;
    logic [LINES-1:0] pend;
    logic [LINES-1:0] masked;
    logic [LINES-1:0] pend_clr;
    logic [LINES-1:0] find_in;
    logic [3:0]       find_idx;
    logic             find_any;
    logic             load_acc;
    logic             xfer;

    assign load_rdy = (state == IDLE);
    assign load_acc = load && !E && load_rdy;
    assign xfer     = valid && ready;
    assign masked   = Y & mask_of(Z);
    assign pend_clr = pend & ~(16'h0001 << X);

    // One finder serves all cases: fresh vector on load, post-transfer
    // remainder when a code is consumed, otherwise the held pend register
    always_comb begin
        find_in = pend;
        if (state == IDLE) begin
            find_in = masked;
        end else if (xfer) begin
            find_in = pend_clr;
        end
    end

    prio_find16 u_find (
        .vec (find_in),
        .idx (find_idx),
        .any (find_any)
    );

    // Population count of the lines still waiting to be issued
    always_comb begin
        pending = 5'd0;
        for (int i = 0; i < LINES; i++) begin
            pending = pending + 5'(pend[i]);
        end
    end

    // FSM, pend register and registered code/valid
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            pend  <= '0;
            X     <= '0;
            valid <= 1'b0;
            none  <= 1'b0;
        end else begin
            none <= 1'b0;
            if (state == IDLE) begin
                if (load_acc) begin
                    if (Z == MODE_RSVD) begin
                        none <= 1'b1;
                    end else begin
                        pend <= masked;
                        if (!find_any) begin
                            none <= 1'b1;
                        end else begin
                            state <= DRAIN;
                            valid <= 1'b1;
                            X     <= CODE_W'(find_idx);
                        end
                    end
                end
            end else begin
                if (xfer) begin
                    pend <= pend_clr;
                    if (!find_any) begin
                        // Last line consumed: back to IDLE with no bubble
                        valid <= 1'b0;
                        state <= IDLE;
                    end else if (!E) begin
                        X <= CODE_W'(find_idx);
                    end else begin
                        valid <= 1'b0;
                    end
                end else if (!valid && !E && find_any) begin
                    // Resume after an enable stall
                    valid <= 1'b1;
                    X     <= CODE_W'(find_idx);
                end
            end
        end
    end

endmodule : priority_encoder_seq
`default_nettype wire

// File: tb/tb_priority_encoder_seq.sv
`default_nettype none
// ============================================================================
//  Module   : tb_priority_encoder_seq
//  Brief    : Directed self-checking bench for priority_encoder_seq.
//  Revision : 1.0  initial release
// ============================================================================
module tb_priority_encoder_seq;

    logic        clk;
    logic        rst;
    logic        E;
    logic [1:0]  Z;
    logic [15:0] Y;
    logic        load;
    logic        load_rdy;
    logic [3:0]  X;
    logic        valid;
    logic        ready;
    logic        none;
    logic [4:0]  pending;

    int n_checks;
    int n_fail;

    priority_encoder_seq #(
        .LINES  (16),
        .CODE_W (4)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .E        (E),
        .Z        (Z),
        .Y        (Y),
        .load     (load),
        .load_rdy (load_rdy),
        .X        (X),
        .valid    (valid),
        .ready    (ready),
        .none     (none),
        .pending  (pending)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one clock; outputs are then settled 1 ns after the edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        rst = 1'b1; E = 1'b0; Z = 2'b00; Y = 16'h0000; load = 1'b0; ready = 1'b0;

        // 1. Reset
        tick();
        tick();
        check("rst_valid",    32'(valid),    32'd0);
        check("rst_X",        32'(X),        32'd0);
        check("rst_pending",  32'(pending),  32'd0);
        check("rst_load_rdy", 32'(load_rdy), 32'd1);
        check("rst_none",     32'(none),     32'd0);
        rst = 1'b0;
        tick();

        // 2. Z=00, Y=00FA -> masked 0xA -> codes 3, 1
        Z = 2'b00; Y = 16'h00FA; load = 1'b1; ready = 1'b1;
        tick();
        load = 1'b0;
        check("t2_valid0",   32'(valid),    32'd1);
        check("t2_X0",       32'(X),        32'd3);
        check("t2_pend0",    32'(pending),  32'd2);
        check("t2_ldrdy0",   32'(load_rdy), 32'd0);
        tick();
        check("t2_valid1",   32'(valid),    32'd1);
        check("t2_X1",       32'(X),        32'd1);
        check("t2_pend1",    32'(pending),  32'd1);
        tick();
        check("t2_valid2",   32'(valid),    32'd0);
        check("t2_pend2",    32'(pending),  32'd0);
        check("t2_ldrdy2",   32'(load_rdy), 32'd1);

        // 3. Z=10, Y=FFFF -> 16 back-to-back codes; a load mid-drain is ignored
        Z = 2'b10; Y = 16'hFFFF; load = 1'b1; ready = 1'b1;
        tick();
        load = 1'b0;
        for (int i = 0; i < 16; i++) begin
            if (i == 5) begin
                load = 1'b1; Z = 2'b00; Y = 16'h0001;
            end
            if (i == 8) begin
                load = 1'b0;
            end
            check("t3_valid", 32'(valid),   32'd1);
            check("t3_X",     32'(X),       32'(15 - i));
            check("t3_pend",  32'(pending), 32'(16 - i));
            check("t3_ldrdy", 32'(load_rdy), 32'd0);
            tick();
        end
        check("t3_valid_end", 32'(valid),    32'd0);
        check("t3_ldrdy_end", 32'(load_rdy), 32'd1);
        check("t3_pend_end",  32'(pending),  32'd0);

        // 4a. Z=01, Y=FF00 -> empty after masking
        Z = 2'b01; Y = 16'hFF00; load = 1'b1;
        tick();
        load = 1'b0;
        check("t4a_none",  32'(none),  32'd1);
        check("t4a_valid", 32'(valid), 32'd0);
        tick();
        check("t4a_none_off", 32'(none),     32'd0);
        check("t4a_valid1",   32'(valid),    32'd0);
        check("t4a_ldrdy",    32'(load_rdy), 32'd1);

        // 4b. Z=11 reserved
        Z = 2'b11; Y = 16'hFFFF; load = 1'b1;
        tick();
        load = 1'b0;
        check("t4b_none",  32'(none),    32'd1);
        check("t4b_valid", 32'(valid),   32'd0);
        check("t4b_pend",  32'(pending), 32'd0);
        tick();
        check("t4b_none_off", 32'(none),  32'd0);
        check("t4b_valid1",   32'(valid), 32'd0);

        // 5. Stall with ready low, then E high during the hold
        Z = 2'b10; Y = 16'h8001; load = 1'b1; ready = 1'b0;
        tick();
        load = 1'b0;
        for (int i = 0; i < 3; i++) begin
            check("t5_hold_valid", 32'(valid),   32'd1);
            check("t5_hold_X",     32'(X),       32'd15);
            check("t5_hold_pend",  32'(pending), 32'd2);
            tick();
        end
        E = 1'b1;
        tick();
        check("t5_Ehold_valid", 32'(valid), 32'd1);
        check("t5_Ehold_X",     32'(X),     32'd15);
        ready = 1'b1;
        tick();
        check("t5_Exfer_valid", 32'(valid),   32'd0);
        check("t5_Exfer_pend",  32'(pending), 32'd1);
        tick();
        check("t5_Estall_valid", 32'(valid),    32'd0);
        check("t5_Estall_pend",  32'(pending),  32'd1);
        check("t5_Estall_ldrdy", 32'(load_rdy), 32'd0);
        E = 1'b0;
        tick();
        check("t5_resume_valid", 32'(valid), 32'd1);
        check("t5_resume_X",     32'(X),     32'd0);
        tick();
        check("t5_done_valid", 32'(valid),    32'd0);
        check("t5_done_pend",  32'(pending),  32'd0);
        check("t5_done_ldrdy", 32'(load_rdy), 32'd1);

        // 6. Reset in the middle of a drain
        Z = 2'b01; Y = 16'h001F; load = 1'b1; ready = 1'b0;
        tick();
        load = 1'b0;
        check("t6_pre_pend",  32'(pending), 32'd5);
        check("t6_pre_X",     32'(X),       32'd4);
        check("t6_pre_valid", 32'(valid),   32'd1);
        rst = 1'b1;
        tick();
        check("t6_rst_valid", 32'(valid),    32'd0);
        check("t6_rst_pend",  32'(pending),  32'd0);
        check("t6_rst_ldrdy", 32'(load_rdy), 32'd1);
        check("t6_rst_X",     32'(X),        32'd0);
        rst = 1'b0;
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_priority_encoder_seq
`default_nettype wire
